// File: rtl/fft_frame_loader.sv
// Collects complex samples into a bit-reversed sample RAM, starts the FFT on each
// full frame, and aborts partial frames that go idle for too long.
module fft_frame_loader #(
    parameter int unsigned bit_width = 32,
    parameter int unsigned N         = 16,
    parameter int unsigned SIZE      = 4,
    parameter logic [15:0] t_timeout = 16'd52070
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_i,
    input  logic signed [bit_width-1:0] re_i,
    input  logic signed [bit_width-1:0] im_i,
    input  logic                        fft_done_i,
    output logic                        wr_en_o,
    output logic [SIZE-1:0]             wr_addr_o,
    output logic signed [bit_width-1:0] wr_re_o,
    output logic signed [bit_width-1:0] wr_im_o,
    output logic                        fft_start_o,
    output logic                        busy_o,
    output logic                        drop_o,
    output logic                        abort_o,
    output logic [15:0]                 frame_cnt_o
);

    typedef enum logic [1:0] {LOAD, START, WAIT} state_t;

    localparam int unsigned      CNT_W      = SIZE + 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(N - 1);
    localparam logic [15:0]      TIMER_LAST = t_timeout - 16'd1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      timer;

    // FFT input ordering: sample k lands at the bit-reversed index of k
    function automatic logic [SIZE-1:0] bit_reverse(input logic [SIZE-1:0] a);
        logic [SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < int'(SIZE); i++) begin
            r[i] = a[SIZE-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            cnt         <= '0;
            timer       <= '0;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            wr_re_o     <= '0;
            wr_im_o     <= '0;
            fft_start_o <= 1'b0;
            busy_o      <= 1'b0;
            drop_o      <= 1'b0;
            abort_o     <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            wr_en_o     <= 1'b0;
            fft_start_o <= 1'b0;
            drop_o      <= 1'b0;
            abort_o     <= 1'b0;
            case (state)
                LOAD: begin
                    if (en_i) begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= bit_reverse(cnt[SIZE-1:0]);
                        wr_re_o   <= re_i;
                        wr_im_o   <= im_i;
                        timer     <= '0;
                        if (cnt == CNT_LAST) begin
                            cnt    <= '0;
                            state  <= START;
                            busy_o <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (cnt != '0) begin
                        // A sample arriving on the terminal count wins over the abort
                        if (timer == TIMER_LAST) begin
                            abort_o <= 1'b1;
                            cnt     <= '0;
                            timer   <= '0;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end else begin
                        timer <= '0;
                    end
                end
                START: begin
                    fft_start_o <= 1'b1;
                    frame_cnt_o <= frame_cnt_o + 16'd1;
                    drop_o      <= en_i;
                    timer       <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    drop_o <= en_i;
                    timer  <= '0;
                    if (fft_done_i) begin
                        state  <= LOAD;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= LOAD;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
